rr_req_agent: RTL and testbench

- Client-side counterpart of the round-robin arbiter: owns the req/gnt interface from the requester end.
- Each of NUM_PORTS clients pushes data words into a private FIFO.
- The agent raises `req_o[p]` while port p holds data.
- On a one-hot `gnt_i` it pops the granted FIFO and forwards the word, with its source port index, to a single shared output stage with valid/ready handshake.

---
 rtl/rr_pkg.sv | 21 ++
 rtl/rr_req_fifo.sv | 63 ++++++
 rtl/rr_req_agent.sv | 100 ++++++++++
 tb/tb_rr_req_agent.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rr_pkg.sv
// rtl/rr_pkg.sv - shared round-robin port types and one-hot helper
package rr_pkg;

    localparam int NUM_PORTS  = 4;
    localparam int PORT_IDX_W = $clog2(NUM_PORTS);

    typedef logic [PORT_IDX_W-1:0] port_idx_t;

    // OR of the indices of set bits; exact for a one-hot input, 0 for zero.
    function automatic port_idx_t onehot_to_idx(input logic [NUM_PORTS-1:0] oh);
        port_idx_t idx;
        idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (oh[i]) begin
                idx = idx | port_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_req_fifo.sv
// rtl/rr_req_fifo.sv - per-port synchronous FIFO with registered occupancy
module rr_req_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic              full;
    logic              empty;
    logic              do_push;
    logic              do_pop;

    // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
    assign full      = (cnt == CW'(DEPTH));
    assign empty     = (cnt == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];
    assign count     = cnt;

    // Pointers wrap naturally modulo DEPTH; count saturates at 0 and DEPTH by gating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset; emptiness is carried by the count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/rr_req_agent.sv
// rtl/rr_req_agent.sv - requester-side agent for the round-robin arbiter
module rr_req_agent
    import rr_pkg::*;
#(
    parameter int NUM_PORTS = rr_pkg::NUM_PORTS,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          in_valid_i,
    output logic [NUM_PORTS-1:0]          in_ready_o,
    input  logic [NUM_PORTS*DATA_W-1:0]   in_data_i,
    output logic [NUM_PORTS-1:0]          req_o,
    input  logic [NUM_PORTS-1:0]          gnt_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [DATA_W-1:0]             out_data_o,
    output logic [$clog2(NUM_PORTS)-1:0]  out_port_o,
    output logic                          err_o
);

    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam int CW    = $clog2(DEPTH) + 1;

    logic [CW-1:0]        count [NUM_PORTS];
    logic [DATA_W-1:0]    head  [NUM_PORTS];
    logic [NUM_PORTS-1:0] push;
    logic [NUM_PORTS-1:0] pop;
    logic [IDX_W-1:0]     gnt_idx;
    logic                 stall;
    logic                 gnt_onehot;
    logic                 gnt_covered;
    logic                 grant_ok;
    logic                 gnt_err;
    logic                 out_valid_q;
    logic [DATA_W-1:0]    out_data_q;
    logic [IDX_W-1:0]     out_port_q;
    logic                 err_q;

    assign stall = out_valid_q && !out_ready_i;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        // Ready and request both derive from the registered count; req is also masked while stalled.
        assign in_ready_o[p] = (count[p] != CW'(DEPTH));
        assign req_o[p]      = (count[p] != '0) && !stall;
        assign push[p]       = in_valid_i[p] && in_ready_o[p];

        rr_req_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (push[p]),
            .push_data (in_data_i[p*DATA_W +: DATA_W]),
            .pop       (pop[p]),
            .head_data (head[p]),
            .count     (count[p])
        );
    end

    // A grant is honoured only if it is one-hot and lands on a port currently requesting.
    assign gnt_onehot  = (gnt_i != '0) && ((gnt_i & (gnt_i - NUM_PORTS'(1))) == '0);
    assign gnt_covered = ((gnt_i & ~req_o) == '0);
    assign grant_ok    = gnt_onehot && gnt_covered;
    assign gnt_err     = (gnt_i != '0) && !grant_ok;
    assign pop         = grant_ok ? gnt_i : '0;
    assign gnt_idx     = onehot_to_idx(gnt_i);

    // Output stage: load on a good grant, drop valid once consumed, otherwise hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_port_q  <= '0;
        end else if (grant_ok) begin
            out_valid_q <= 1'b1;
            out_data_q  <= head[gnt_idx];
            out_port_q  <= gnt_idx;
        end else if (out_ready_i || !out_valid_q) begin
            out_valid_q <= 1'b0;
        end
    end

    // Protocol error flag stays set until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (gnt_err) begin
            err_q <= 1'b1;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_port_o  = out_port_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_rr_req_agent.sv
// tb/tb_rr_req_agent.sv - directed self-checking bench for rr_req_agent
module tb_rr_req_agent;

    logic        clk;
    logic        reset;
    logic [3:0]  in_valid_i;
    logic [3:0]  in_ready_o;
    logic [31:0] in_data_i;
    logic [3:0]  req_o;
    logic [3:0]  gnt_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [7:0]  out_data_o;
    logic [1:0]  out_port_o;
    logic        err_o;

    int checks;
    int errors;

    rr_req_agent #(
        .NUM_PORTS (4),
        .DATA_W    (8),
        .DEPTH     (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .req_o       (req_o),
        .gnt_i       (gnt_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_port_o  (out_port_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int p, input logic [7:0] d);
        in_valid_i = '0;
        in_valid_i[p] = 1'b1;
        in_data_i[p*8 +: 8] = d;
        step();
        in_valid_i = '0;
    endtask

    task automatic out_chk(input string tag, input logic v, input logic [7:0] d, input logic [1:0] p);
        chk({tag, "_valid"}, 32'(out_valid_o), 32'(v));
        chk({tag, "_data"},  32'(out_data_o),  32'(d));
        chk({tag, "_port"},  32'(out_port_o),  32'(p));
    endtask

    logic [7:0] drain_exp [4];

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b0;
        in_valid_i  = '0;
        in_data_i   = '0;
        gnt_i       = '0;
        out_ready_i = 1'b1;
        drain_exp[0] = 8'h11;
        drain_exp[1] = 8'h12;
        drain_exp[2] = 8'h13;
        drain_exp[3] = 8'h15;

        // reset values
        repeat (3) step();
        chk("rst_ready", 32'(in_ready_o), 32'hF);
        chk("rst_req",   32'(req_o),      32'h0);
        chk("rst_err",   32'(err_o),      32'h0);
        out_chk("rst", 1'b0, 8'h00, 2'd0);
        reset = 1'b1;
        step();

        // single push then grant: one-cycle grant-to-output latency
        push(1, 8'hA1);
        chk("push_req", 32'(req_o), 32'h2);
        gnt_i = 4'b0010;
        step();
        gnt_i = '0;
        #1;
        out_chk("gnt1", 1'b1, 8'hA1, 2'd1);
        chk("gnt1_req_drop", 32'(req_o), 32'h0);
        step();
        chk("gnt1_clear", 32'(out_valid_o), 32'h0);

        // fill port 0, refused push on the full+pop cycle, then in-order drain
        for (int i = 0; i < 4; i++) push(0, 8'h10 + 8'(i));
        chk("full_ready", 32'(in_ready_o), 32'hE);
        chk("full_req",   32'(req_o),      32'h1);
        gnt_i = 4'b0001;
        in_valid_i = 4'b0001;
        in_data_i[7:0] = 8'h14;
        step();
        gnt_i = '0;
        in_valid_i = '0;
        #1;
        out_chk("full_pop", 1'b1, 8'h10, 2'd0);
        chk("refused_ready", 32'(in_ready_o), 32'hF);
        push(0, 8'h15);
        chk("refill_ready", 32'(in_ready_o), 32'hE);
        for (int i = 0; i < 4; i++) begin
            gnt_i = 4'b0001;
            step();
            chk("drain_data", 32'(out_data_o), 32'(drain_exp[i]));
            chk("drain_valid", 32'(out_valid_o), 32'h1);
        end
        gnt_i = '0;
        #1;
        chk("drain_req",   32'(req_o),      32'h0);
        chk("drain_ready", 32'(in_ready_o), 32'hF);
        step();
        chk("drain_clear", 32'(out_valid_o), 32'h0);

        // stall: held word stable, requests masked, restored when ready rises
        push(2, 8'h55);
        push(2, 8'h66);
        gnt_i = 4'b0100;
        step();
        gnt_i = '0;
        out_ready_i = 1'b0;
        #1;
        chk("stall_req0", 32'(req_o), 32'h0);
        out_chk("stall0", 1'b1, 8'h55, 2'd2);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_req", 32'(req_o), 32'h0);
            out_chk("stall", 1'b1, 8'h55, 2'd2);
        end
        out_ready_i = 1'b1;
        #1;
        chk("unstall_req", 32'(req_o), 32'h4);
        step();
        chk("unstall_valid", 32'(out_valid_o), 32'h0);
        chk("unstall_req2",  32'(req_o),       32'h4);
        gnt_i = 4'b0100;
        step();
        gnt_i = '0;
        #1;
        out_chk("stall_drain", 1'b1, 8'h66, 2'd2);
        step();

        // multi-hot grant: no pop, sticky error
        in_valid_i = 4'b0110;
        in_data_i  = 32'h0022_1100;
        step();
        in_valid_i = '0;
        chk("mh_req", 32'(req_o), 32'h6);
        gnt_i = 4'b0110;
        step();
        gnt_i = '0;
        #1;
        chk("mh_err",   32'(err_o),       32'h1);
        chk("mh_valid", 32'(out_valid_o), 32'h0);
        chk("mh_req2",  32'(req_o),       32'h6);
        step();
        step();
        chk("mh_err_hold", 32'(err_o), 32'h1);
        gnt_i = 4'b0010;
        step();
        out_chk("mh_p1", 1'b1, 8'h11, 2'd1);
        gnt_i = 4'b0100;
        step();
        gnt_i = '0;
        #1;
        out_chk("mh_p2", 1'b1, 8'h22, 2'd2);
        chk("mh_req_end", 32'(req_o), 32'h0);
        chk("mh_err_end", 32'(err_o), 32'h1);
        step();

        // asynchronous reset mid-stream flushes FIFOs and the held word
        for (int i = 0; i < 4; i++) push(2, 8'h30 + 8'(i));
        gnt_i = 4'b0100;
        step();
        gnt_i = '0;
        #1;
        out_chk("pre_rst", 1'b1, 8'h30, 2'd2);
        chk("pre_rst_req", 32'(req_o), 32'h4);
        reset = 1'b0;
        #1;
        out_chk("mid_rst", 1'b0, 8'h00, 2'd0);
        chk("mid_rst_req",   32'(req_o),      32'h0);
        chk("mid_rst_ready", 32'(in_ready_o), 32'hF);
        chk("mid_rst_err",   32'(err_o),      32'h0);
        step();
        reset = 1'b1;
        step();
        step();
        chk("post_rst_req",   32'(req_o),       32'h0);
        chk("post_rst_valid", 32'(out_valid_o), 32'h0);

        // grant to an empty port is an error and produces no output
        gnt_i = 4'b1000;
        step();
        gnt_i = '0;
        #1;
        chk("empty_gnt_err",   32'(err_o),       32'h1);
        chk("empty_gnt_valid", 32'(out_valid_o), 32'h0);
        step();
        chk("empty_gnt_hold", 32'(err_o), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
